// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_fa.sv
// Combinational 1-bit full adder used as the serial adder's bit datapath.
// Zero latency; no flow control.
module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: one LOAD edge, WIDTH SHIFT edges, then holds {c_out,S} in DONE until reset.
// Latency WIDTH+1 edges from reset release; no backpressure. Optional done port under SERIAL_ADD_DONE_EN.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] S,
  output logic             c_out
`ifdef SERIAL_ADD_DONE_EN
  ,
  output logic             done
`endif
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_shift;

  serial_add_fa u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // LSB-first: each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        a_sr_d  = a;
        b_sr_d  = b;
        carry_d = c_in;
        cnt_d   = '0;
        sum_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sum_d   = sum_shift;
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = sum_shift;
          cout_d  = fa_co;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S     = s_q;
  assign c_out = cout_q;

`ifdef SERIAL_ADD_DONE_EN
  logic done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == DONE);
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add (WIDTH=4): fixed vectors, reset abort, input isolation, full sweep.
module tb_serial_add;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] S;
  logic       c_out;
`ifdef SERIAL_ADD_DONE_EN
  logic       done;
`endif

  int total = 0;
  int bad   = 0;

  serial_add #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .S     (S),
    .c_out (c_out)
`ifdef SERIAL_ADD_DONE_EN
    ,
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reset pulse, release, and check: zero before the 5th edge, result on it, result held afterwards.
  task automatic run(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                     input logic [4:0] exp, input string tag);
    @(negedge clk);
    rst  = 1'b0;
    a    = ta;
    b    = tb_v;
    c_in = tc;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk({tag, "_busy"}, {3'b0, c_out, S}, 8'd0);
    @(posedge clk);
    #1 chk({tag, "_res"}, {3'b0, c_out, S}, {3'b0, exp});
`ifdef SERIAL_ADD_DONE_EN
    chk({tag, "_done"}, {7'b0, done}, 8'd1);
`endif
    a    = ~ta;
    b    = ~tb_v;
    c_in = ~tc;
    repeat (3) @(posedge clk);
    #1 chk({tag, "_hold"}, {3'b0, c_out, S}, {3'b0, exp});
  endtask

  initial begin
    rst  = 1'b0;
    a    = 4'd9;
    b    = 4'd9;
    c_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {3'b0, c_out, S}, 8'd0);

    run(4'd3,  4'd5,  1'b0, 5'd8,  "r026");
    run(4'd15, 4'd1,  1'b0, 5'd16, "r027");
    run(4'd15, 4'd15, 1'b1, 5'd31, "r028");
    run(4'd10, 4'd3,  1'b1, 5'd14, "mixed");

    // Abort in DONE: outputs must clear asynchronously, before any clock edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("abort_done", {3'b0, c_out, S}, 8'd0);
`ifdef SERIAL_ADD_DONE_EN
    chk("abort_done_flag", {7'b0, done}, 8'd0);
`endif

    // Abort after the 2nd SHIFT edge, then rerun from a fresh LOAD.
    a    = 4'd9;
    b    = 4'd9;
    c_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("abort_shift", {3'b0, c_out, S}, 8'd0);
`ifdef SERIAL_ADD_DONE_EN
    chk("abort_shift_flag", {7'b0, done}, 8'd0);
`endif
    run(4'd6, 4'd7, 1'b0, 5'd13, "r030");

    // Inputs zeroed mid-SHIFT must not disturb the captured operands: 12+9 = 21.
    @(negedge clk);
    rst  = 1'b0;
    a    = 4'd12;
    b    = 4'd9;
    c_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a    = 4'd0;
    b    = 4'd0;
    c_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("r031", {3'b0, c_out, S}, 8'd21);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          run(4'(i), 4'(j), 1'(k), 5'(i + j + k), $sformatf("sweep_%0d_%0d_%0d", i, j, k));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
